// File: rtl/iot_byte_tx.sv
// -----------------------------------------------------------------------------
// iot_byte_tx
// Source side of the IOTDF byte-stream input interface. Accepts 128-bit IoT
// data words over a valid/ready handshake and serializes each one into 16
// bytes, most significant byte first, on iot_in/in_en. The sink's busy input
// stalls the stream in place. A session carries NUM_WORDS words and ends in
// DONE after the final byte has been issued.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-low reset
//   start       in   1      one-cycle pulse, begins a session from IDLE/DONE
//   word_valid  in   1      word_data is valid
//   word_data   in   128    word to send, bits [127:120] go out first
//   word_ready  out  1      a word can be accepted this cycle
//   busy        in   1      sink busy, no byte issues at an edge where high
//   in_en       out  1      registered, iot_in carries a valid byte
//   iot_in      out  8      registered byte, 8'h00 whenever in_en is low
//   word_cnt    out  CNT_W  words fully transmitted this session
//   done        out  1      high while in DONE
// -----------------------------------------------------------------------------
module iot_byte_tx #(
    parameter int NUM_WORDS = 96,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             word_valid,
    input  logic [127:0]     word_data,
    output logic             word_ready,
    input  logic             busy,
    output logic             in_en,
    output logic [7:0]       iot_in,
    output logic [CNT_W-1:0] word_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    state_t             state_q,    state_d;
    logic [127:0]       sh_q,       sh_d;
    logic               sh_vld_q,   sh_vld_d;
    logic [127:0]       hold_q,     hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0]   acc_cnt_q,  acc_cnt_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic               in_en_q,    in_en_d;
    logic [7:0]         iot_in_q,   iot_in_d;
    logic               done_q,     done_d;

    logic               accept_s;
    logic               issue_s;
    logic               last_s;

    // Ready depends on registered state only, so the source may wait for it
    // before raising word_valid without creating a combinational loop.
    assign word_ready = (state_q == ST_SEND) && !hold_vld_q && (acc_cnt_q < NUM_C);

    assign accept_s = word_valid && word_ready;
    assign issue_s  = (state_q == ST_SEND) && sh_vld_q && !busy;
    assign last_s   = issue_s && (byte_idx_q == 4'd15);

    // Next-state computation for the session FSM and the two word buffers.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        acc_cnt_d  = acc_cnt_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        in_en_d    = 1'b0;
        iot_in_d   = 8'h00;
        done_d     = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_SEND;
                    word_cnt_d = ZERO_C;
                    acc_cnt_d  = ZERO_C;
                    byte_idx_d = 4'd0;
                    sh_vld_d   = 1'b0;
                    hold_vld_d = 1'b0;
                    done_d     = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_SEND: begin
                if (issue_s) begin
                    in_en_d    = 1'b1;
                    iot_in_d   = sh_q[127:120];
                    sh_d       = {sh_q[119:0], 8'h00};
                    byte_idx_d = byte_idx_q + 4'd1;
                    if (last_s) begin
                        word_cnt_d = word_cnt_q + ONE_C;
                        // Refill sh on the same edge so the next word's first
                        // byte follows without a bubble.
                        if (hold_vld_q) begin
                            sh_d       = hold_q;
                            hold_vld_d = 1'b0;
                        end else if (accept_s) begin
                            sh_d = word_data;
                        end else begin
                            sh_vld_d = 1'b0;
                        end
                        if ((word_cnt_q + ONE_C) == NUM_C) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end else if (accept_s) begin
                        hold_d     = word_data;
                        hold_vld_d = 1'b1;
                    end else begin
                        hold_vld_d = hold_vld_q;
                    end
                end else if (accept_s) begin
                    if (!sh_vld_q) begin
                        sh_d     = word_data;
                        sh_vld_d = 1'b1;
                    end else begin
                        hold_d     = word_data;
                        hold_vld_d = 1'b1;
                    end
                end else begin
                    sh_vld_d = sh_vld_q;
                end

                if (accept_s) begin
                    acc_cnt_d = acc_cnt_q + ONE_C;
                end else begin
                    acc_cnt_d = acc_cnt_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops in_en immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= 128'h0;
            sh_vld_q   <= 1'b0;
            hold_q     <= 128'h0;
            hold_vld_q <= 1'b0;
            acc_cnt_q  <= ZERO_C;
            word_cnt_q <= ZERO_C;
            byte_idx_q <= 4'd0;
            in_en_q    <= 1'b0;
            iot_in_q   <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            sh_vld_q   <= sh_vld_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            acc_cnt_q  <= acc_cnt_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            in_en_q    <= in_en_d;
            iot_in_q   <= iot_in_d;
            done_q     <= done_d;
        end
    end

    assign in_en    = in_en_q;
    assign iot_in   = iot_in_q;
    assign word_cnt = word_cnt_q;
    assign done     = done_q;

endmodule

// File: doc/iot_byte_tx.md
Name: iot_byte_tx

Overview:
- Source side of the IOTDF byte-stream input interface.
- Accepts 128-bit IoT data words over a valid/ready handshake and serializes each into 16 bytes, MSB byte first, on iot_in/in_en.
- Honours the sink's busy back-pressure and counts a session of NUM_WORDS words.
- Replaces behavioural pattern feeding, so IOTDF can be driven from on-chip sources and synthesized system wrappers.

Parameters:
- NUM_WORDS, 96, 128-bit words per session; done asserts after the last byte of the last word.
- CNT_W, $clog2(NUM_WORDS+1), width of word_cnt.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a session from IDLE or DONE.
- word_valid  in  1  word_data valid.
- word_data  in  128  word to send; bits [127:120] are sent first.
- word_ready  out  1  word can be accepted this cycle.
- busy  in  1  sink busy; no byte is issued at an edge where busy=1.
- in_en  out  1  registered; iot_in holds a valid byte.
- iot_in  out  8  registered byte; 8'h00 whenever in_en=0.
- word_cnt  out  CNT_W  words fully transmitted this session.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_en=0; iot_in=0; word_ready=0; word_cnt=0; done=0; shift/hold buffers invalid; acc_cnt=0; byte_idx=0.
- States:
  - IDLE: start -> SEND; clears word_cnt and acc_cnt.
  - SEND: at the edge where word_cnt reaches NUM_WORDS -> DONE.
  - DONE: done=1; start -> SEND with counters cleared; start in SEND is ignored.
- Buffers: shift register sh with sh_vld; one-entry hold register hold with hold_vld.
- word_ready = (state==SEND) && !hold_vld && (acc_cnt < NUM_WORDS). This is combinational from registers only; it never depends on word_valid.
- Accept happens when word_valid && word_ready at an edge; acc_cnt increments.
  - Goes directly into sh if sh is empty after this edge (sh_vld=0, or its last byte issues this edge). Otherwise goes into hold.
- Byte issue at an edge when state==SEND && sh_vld && busy==0:
  - in_en<=1; iot_in<=sh[127:120]; sh<=sh<<8; byte_idx++ (4-bit, wraps 15->0).
  - At byte_idx==15: word_cnt++. sh reloads from hold if hold_vld (hold_vld<=0); otherwise sh_vld<=0.
- Any other edge: in_en<=0; iot_in<=0. busy stalls in place; no byte is skipped or duplicated.
- Latency:
  - Word accepted into empty sh at edge E: first byte (in_en=1) after edge E+1 if busy=0 at E+1.
  - With hold full: byte 0 of word n+1 follows byte 15 of word n on the next edge, so 16*k bytes go out in 16*k consecutive cycles when busy stays 0.
- Session end:
  - acc_cnt==NUM_WORDS forces word_ready=0.
  - DONE entered at the same edge that issues the final byte; in_en falls at the next edge.
- Reset mid-word: partial word discarded, in_en drops asynchronously; no resumption after reset.

Test Plan:
- Session with NUM_WORDS=1, busy=0, word 128'h00112233_44556677_8899AABB_CCDDEEFF -> 16 consecutive in_en cycles, iot_in = 00,11,...,FF in order, word_cnt=1, done=1, word_ready=0.
- busy high for 3 edges after byte 5 of word 128'h0F0E..00 -> in_en=0 for exactly 3 cycles with iot_in=00; resumes with byte 6 (0x09); 16 bytes total, none repeated.
- Two words presented back-to-back with word_valid held high -> second word accepted into hold while the first shifts; 32 consecutive in_en cycles; word_cnt 1 then 2.
- NUM_WORDS=2, third word offered with word_valid=1 -> word_ready stays 0, third word never accepted; done after the 32nd byte; start then clears word_cnt to 0.
- rst pulsed low after byte 7 of a word -> in_en=0, iot_in=00 immediately; state IDLE, word_ready=0; no bytes until the next start plus a new word.
- start pulsed while in SEND -> ignored; word_cnt and acc_cnt are not cleared.
